c1_bus_master: RTL and testbench
================================

C1_BUS_MASTER -- requirements
Module: c1_bus_master

Interface
REQ-001 The module SHALL have parameter MEM_ADDR_SIZE, default 19, meaning the byte-address width.
REQ-002 The module SHALL have parameter BUS_SIZE, default 16, meaning the C1 data bus width in bits (>=8).
REQ-003 The module SHALL have parameter CACHE_OFFSET_SIZE, default 4, meaning the line-offset width.
REQ-004 The module SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum response wait in cycles; 0 disables the timeout.
REQ-005 The module SHALL use one clock and a synchronous, active-low reset, with these ports:
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when high with req_valid
- req_cmd  in  3  C1 command code
- req_addr  in  MEM_ADDR_SIZE  byte address
- req_wdata  in  2*BUS_SIZE  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  2*BUS_SIZE  read data
- rsp_err  out  1  timeout flag, qualified by rsp_valid
- busy  out  1  transaction in flight
- c1_addr  out  MEM_ADDR_SIZE-CACHE_OFFSET_SIZE  C1 address bus
- c1_data_out  out  BUS_SIZE  C1 data driven
- c1_data_oe  out  1  C1 data drive enable
- c1_data_in  in  BUS_SIZE  C1 data sampled
- c1_cmd_out  out  3  C1 command driven
- c1_cmd_oe  out  1  C1 command drive enable
- c1_cmd_in  in  3  C1 command sampled

Function
REQ-006 The command codes SHALL be: NOP=0, READ8=1, READ16=2, READ32=3, INV_LINE=4, WRITE8=5, WRITE16=6, WRITE32_RESP=7.
REQ-007 The FSM SHALL have states IDLE, ADDR0, ADDR1, WAIT, RD_HI and DONE; req_ready SHALL be high only in IDLE, and busy SHALL be high in every state except IDLE.
REQ-008 On acceptance in IDLE, the block SHALL latch req_cmd, req_addr and req_wdata and go to ADDR0; a NOP SHALL go directly to DONE, with no bus activity.
REQ-009 In ADDR0: c1_cmd_oe=1, c1_cmd_out=command, c1_addr=addr[MEM_ADDR_SIZE-1:CACHE_OFFSET_SIZE]; next state is ADDR1.
REQ-010 In ADDR1: c1_cmd_oe=1, c1_addr=addr[CACHE_OFFSET_SIZE-1:0] zero-extended; next state is WAIT.
REQ-011 Data drive:
- WRITE8/16: c1_data_oe=1 and c1_data_out=wdata[BUS_SIZE-1:0] from ADDR0 through the end of WAIT.
- WRITE32: low word in ADDR0, high word in ADDR1, and the high word held during WAIT.
- Reads, INV_LINE and NOP: c1_data_oe=0 throughout.
REQ-012 In WAIT, c1_cmd_oe SHALL be 0, and a response SHALL be exactly c1_cmd_in==3'b111 (X/Z or any other value is not a response), sampled from the first WAIT cycle.
REQ-013 On a response: READ8 SHALL capture c1_data_in[7:0] zero-extended, READ16 SHALL capture c1_data_in zero-extended, and both SHALL go to DONE; READ32 SHALL capture the low word and go to RD_HI; all other commands SHALL go to DONE.
REQ-014 RD_HI SHALL capture c1_data_in into the high word unconditionally on the next cycle, then go to DONE.
REQ-015 If TIMEOUT_CYCLES>0 and TIMEOUT_CYCLES WAIT cycles pass without a response, the block SHALL go to DONE with rsp_err=1 and rsp_rdata=0.
REQ-016 DONE SHALL assert rsp_valid for exactly one cycle and then return to IDLE; rsp_rdata and rsp_err SHALL hold until the next DONE.
REQ-017 The minimum latency from acceptance edge to rsp_valid SHALL be 4 cycles for non-READ32 commands and 5 cycles for READ32; a NOP SHALL take 1 cycle.
REQ-018 A response arriving in the same cycle the timeout expires SHALL win, with rsp_err=0.

Reset
REQ-019 When rst_n=0 at a posedge, the block SHALL go to IDLE from any state, including mid-transaction, and abandon the transaction with no rsp_valid.
REQ-020 Reset values SHALL be: all *_oe=0, c1_addr=0, c1_data_out=0, c1_cmd_out=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, req_ready=1 and timeout counter=0.

Structure
REQ-021 Package c1_pkg SHALL hold the c1_cmd_t command enum and the FSM state typedef.
REQ-022 A sub-module c1_wait_timer SHALL implement the parameterised WAIT-cycle counter and its expiry flag.

Verification
REQ-023 READ32 at 0x001E0 with the responder answering 2 cycles into WAIT and then supplying data 0xAAAA, 0x5555 -> rsp_rdata=0x5555AAAA, rsp_err=0, latency 7 cycles.
REQ-024 WRITE32 of 0xF0F00F0F to 0x004E0 -> c1_data_out is 0x0F0F in ADDR0 and 0xF0F0 in ADDR1, c1_addr is 0x004E then 0x0, and rsp_valid follows the response.
REQ-025 READ8 returning c1_data_in=0x12AB -> rsp_rdata=0x000000AB.
REQ-026 INV_LINE with no responder and TIMEOUT_CYCLES=64 -> rsp_valid with rsp_err=1 exactly 64 WAIT cycles later, and the next request is accepted.
REQ-027 rst_n pulled low during WAIT of a WRITE16 -> both oe signals are 0 next cycle, there is no rsp_valid, and req_ready=1.
REQ-028 c1_cmd_in=3'bzzz or 3'b110 during WAIT -> it is ignored; 3'b111 arriving on the expiry cycle completes with rsp_err=0.

Source files
------------

// File: rtl/c1_pkg.sv
// c1_pkg -- shared types for the C1 bus master.
//   c1_cmd_t   : C1 command codes as they appear on the command bus
//   c1_state_t : transaction FSM states of c1_bus_master
//   C1_RSP_CODE: command-bus value a responder drives to complete a transaction
package c1_pkg;

    typedef enum logic [2:0] {
        CMD_NOP          = 3'd0,
        CMD_READ8        = 3'd1,
        CMD_READ16       = 3'd2,
        CMD_READ32       = 3'd3,
        CMD_INV_LINE     = 3'd4,
        CMD_WRITE8       = 3'd5,
        CMD_WRITE16      = 3'd6,
        CMD_WRITE32_RESP = 3'd7
    } c1_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR0 = 3'd1,
        ST_ADDR1 = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RD_HI = 3'd4,
        ST_DONE  = 3'd5
    } c1_state_t;

    localparam logic [2:0] C1_RSP_CODE = 3'b111;

endpackage

// File: rtl/c1_wait_timer.sv
// c1_wait_timer -- counts consecutive cycles with en high and flags expiry.
//   clk     : clock
//   rst_n   : synchronous active-low reset
//   en      : high while the master sits in WAIT; low clears the count
//   expired : high during the TIMEOUT_CYCLES-th consecutive enabled cycle
//             (never high when TIMEOUT_CYCLES is 0)
module c1_wait_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] cnt;

    // Count is 0 in the first enabled cycle, so expiry lands on cycle TIMEOUT_CYCLES.
    // Wrapping is harmless: the master leaves WAIT on expiry, and with the
    // timeout disabled the count is never compared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

    assign expired = (TIMEOUT_CYCLES > 0) && en && (cnt == LAST);

endmodule

// File: rtl/c1_bus_master.sv
// c1_bus_master -- single-outstanding request master for the C1 bus.
//   Request side : req_valid/req_ready handshake with req_cmd, req_addr, req_wdata
//   Response side: rsp_valid one-cycle pulse, rsp_rdata, rsp_err (timeout)
//   busy         : high whenever a transaction is in flight
//   C1 side      : c1_addr, c1_cmd_out/c1_cmd_oe/c1_cmd_in, c1_data_out/c1_data_oe/c1_data_in
// A transaction is ADDR0 (line address + command), ADDR1 (line offset),
// WAIT (until c1_cmd_in==3'b111 or timeout), RD_HI (second word of READ32),
// DONE (rsp_valid). NOP skips straight to DONE.
module c1_bus_master
    import c1_pkg::*;
#(
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int BUS_SIZE          = 16,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int TIMEOUT_CYCLES    = 64
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     req_valid,
    output logic                                     req_ready,
    input  logic [2:0]                               req_cmd,
    input  logic [MEM_ADDR_SIZE-1:0]                 req_addr,
    input  logic [2*BUS_SIZE-1:0]                    req_wdata,
    output logic                                     rsp_valid,
    output logic [2*BUS_SIZE-1:0]                    rsp_rdata,
    output logic                                     rsp_err,
    output logic                                     busy,
    output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] c1_addr,
    output logic [BUS_SIZE-1:0]                      c1_data_out,
    output logic                                     c1_data_oe,
    input  logic [BUS_SIZE-1:0]                      c1_data_in,
    output logic [2:0]                               c1_cmd_out,
    output logic                                     c1_cmd_oe,
    input  logic [2:0]                               c1_cmd_in
);

    localparam int AW = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int RW = 2 * BUS_SIZE;

    c1_state_t              state, state_nxt;
    c1_cmd_t                cmd_q;
    logic [MEM_ADDR_SIZE-1:0] addr_q;
    logic [RW-1:0]          wdata_q;
    logic [BUS_SIZE-1:0]    rd_lo_q;

    logic                   rsp_hit;
    logic                   tmo_expired;
    logic                   is_write;
    logic                   load_rsp;
    logic [RW-1:0]          rsp_rdata_nxt;
    logic                   rsp_err_nxt;

    // Zero-extended read result for single-word reads.
    function automatic logic [RW-1:0] read_format(input c1_cmd_t cmd,
                                                  input logic [BUS_SIZE-1:0] data);
        case (cmd)
            CMD_READ8:  return RW'(data[7:0]);
            CMD_READ16: return RW'(data);
            default:    return '0;
        endcase
    endfunction

    c1_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state == ST_WAIT),
        .expired(tmo_expired)
    );

    // Only the exact code counts; X/Z compares unknown and is treated as no response.
    assign rsp_hit  = (state == ST_WAIT) && (c1_cmd_in == C1_RSP_CODE);
    assign is_write = (cmd_q == CMD_WRITE8) || (cmd_q == CMD_WRITE16) ||
                      (cmd_q == CMD_WRITE32_RESP);

    // ---- state register and response registers ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_rsp) begin
                rsp_rdata <= rsp_rdata_nxt;
                rsp_err   <= rsp_err_nxt;
            end
        end
    end

    // ---- transaction context (data only) ----
    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            cmd_q   <= c1_cmd_t'(req_cmd);
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
        if (rsp_hit && (cmd_q == CMD_READ32)) begin
            rd_lo_q <= c1_data_in;
        end
    end

    // ---- next state; response registers load only on entry to DONE ----
    always_comb begin
        state_nxt     = state;
        load_rsp      = 1'b0;
        rsp_rdata_nxt = '0;
        rsp_err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_cmd == CMD_NOP) begin
                        state_nxt = ST_DONE;
                        load_rsp  = 1'b1;
                    end else begin
                        state_nxt = ST_ADDR0;
                    end
                end
            end
            ST_ADDR0: state_nxt = ST_ADDR1;
            ST_ADDR1: state_nxt = ST_WAIT;
            ST_WAIT: begin
                // A response in the expiry cycle takes priority over the timeout.
                if (rsp_hit) begin
                    if (cmd_q == CMD_READ32) begin
                        state_nxt = ST_RD_HI;
                    end else begin
                        state_nxt     = ST_DONE;
                        load_rsp      = 1'b1;
                        rsp_rdata_nxt = read_format(cmd_q, c1_data_in);
                    end
                end else if (tmo_expired) begin
                    state_nxt   = ST_DONE;
                    load_rsp    = 1'b1;
                    rsp_err_nxt = 1'b1;
                end
            end
            ST_RD_HI: begin
                state_nxt     = ST_DONE;
                load_rsp      = 1'b1;
                rsp_rdata_nxt = {c1_data_in, rd_lo_q};
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // ---- bus outputs decoded from state ----
    always_comb begin
        req_ready   = (state == ST_IDLE);
        busy        = (state != ST_IDLE);
        rsp_valid   = (state == ST_DONE);
        c1_addr     = '0;
        c1_cmd_out  = 3'b000;
        c1_cmd_oe   = 1'b0;
        c1_data_out = '0;
        c1_data_oe  = 1'b0;
        case (state)
            ST_ADDR0: begin
                c1_cmd_oe  = 1'b1;
                c1_cmd_out = cmd_q;
                c1_addr    = addr_q[MEM_ADDR_SIZE-1:CACHE_OFFSET_SIZE];
            end
            ST_ADDR1: begin
                c1_cmd_oe  = 1'b1;
                c1_cmd_out = cmd_q;
                c1_addr    = AW'(addr_q[CACHE_OFFSET_SIZE-1:0]);
            end
            default: ;
        endcase
        // Write data is held from ADDR0 to the end of WAIT; WRITE32 switches
        // to its high word after ADDR0.
        if (is_write && ((state == ST_ADDR0) || (state == ST_ADDR1) || (state == ST_WAIT))) begin
            c1_data_oe = 1'b1;
            if ((cmd_q == CMD_WRITE32_RESP) && (state != ST_ADDR0)) begin
                c1_data_out = wdata_q[RW-1:BUS_SIZE];
            end else begin
                c1_data_out = wdata_q[BUS_SIZE-1:0];
            end
        end
    end

endmodule

// File: tb/tb_c1_bus_master.sv
module tb_c1_bus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cmd;
    logic [18:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [14:0] c1_addr;
    logic [15:0] c1_data_out;
    logic        c1_data_oe;
    logic [15:0] c1_data_in;
    logic [2:0]  c1_cmd_out;
    logic        c1_cmd_oe;
    logic [2:0]  c1_cmd_in;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    c1_bus_master #(
        .MEM_ADDR_SIZE(19),
        .BUS_SIZE(16),
        .CACHE_OFFSET_SIZE(4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .c1_addr    (c1_addr),
        .c1_data_out(c1_data_out),
        .c1_data_oe (c1_data_oe),
        .c1_data_in (c1_data_in),
        .c1_cmd_out (c1_cmd_out),
        .c1_cmd_oe  (c1_cmd_oe),
        .c1_cmd_in  (c1_cmd_in)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a request at the current negedge; returns one negedge after the acceptance edge.
    task automatic accept(input logic [2:0] cmd, input logic [18:0] addr, input logic [31:0] wdata,
                          input string tag);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        req_wdata = wdata;
        check({tag, ".req_ready"}, 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // rsp_at: cycle (counted from acceptance) in which 3'b111 is driven; 0 = never.
    task automatic run_txn(input logic [2:0] cmd, input logic [18:0] addr, input logic [31:0] wdata,
                           input int rsp_at, input logic [15:0] lo, input logic [15:0] hi,
                           input logic chk_data, input logic [31:0] exp_rdata, input logic exp_err,
                           input int exp_lat, input string tag);
        exp_t e;
        exp_t got;
        int   lat;
        logic done;
        logic wr;
        logic [15:0] wd_hi_or_lo;
        e.rdata = exp_rdata;
        e.err = exp_err;
        e.lat = exp_lat;
        e.chk_data = chk_data;
        sb.push_back(e);
        wr = (cmd == 3'd5) || (cmd == 3'd6) || (cmd == 3'd7);
        wd_hi_or_lo = (cmd == 3'd7) ? wdata[31:16] : wdata[15:0];
        accept(cmd, addr, wdata, tag);
        lat = 1;
        done = 1'b0;
        while (!done && lat <= 200) begin
            if (cmd == 3'd0 && lat == 1) begin
                check({tag, ".nop_cmd_oe"}, 64'(c1_cmd_oe), 64'd0);
                check({tag, ".nop_data_oe"}, 64'(c1_data_oe), 64'd0);
            end
            if (cmd != 3'd0 && lat == 1) begin
                check({tag, ".a0_busy"}, 64'(busy), 64'd1);
                check({tag, ".a0_cmd_oe"}, 64'(c1_cmd_oe), 64'd1);
                check({tag, ".a0_cmd_out"}, 64'(c1_cmd_out), 64'(cmd));
                check({tag, ".a0_addr"}, 64'(c1_addr), 64'(addr[18:4]));
                check({tag, ".a0_data_oe"}, 64'(c1_data_oe), 64'(wr));
                if (wr) check({tag, ".a0_data"}, 64'(c1_data_out), 64'(wdata[15:0]));
            end
            if (cmd != 3'd0 && lat == 2) begin
                check({tag, ".a1_cmd_oe"}, 64'(c1_cmd_oe), 64'd1);
                check({tag, ".a1_addr"}, 64'(c1_addr), 64'(addr[3:0]));
                check({tag, ".a1_data_oe"}, 64'(c1_data_oe), 64'(wr));
                if (wr) check({tag, ".a1_data"}, 64'(c1_data_out), 64'(wd_hi_or_lo));
            end
            if (cmd != 3'd0 && lat == 3) begin
                check({tag, ".w_cmd_oe"}, 64'(c1_cmd_oe), 64'd0);
                check({tag, ".w_data_oe"}, 64'(c1_data_oe), 64'(wr));
                if (wr) check({tag, ".w_data"}, 64'(c1_data_out), 64'(wd_hi_or_lo));
            end
            // Responder: anything but 3'b111 is noise, alternating 110 and zzz.
            if (lat == rsp_at) c1_cmd_in = 3'b111;
            else if (lat % 2 == 1) c1_cmd_in = 3'b110;
            else c1_cmd_in = 3'bzzz;
            if (lat == rsp_at) c1_data_in = lo;
            else if (rsp_at != 0 && lat == rsp_at + 1) c1_data_in = hi;
            else c1_data_in = 16'hDEAD;
            if (rsp_valid) begin
                done = 1'b1;
                checks++;
                assert (sb.size() > 0)
                else begin
                    failures++;
                    $error("FAIL %s.sb_empty observed=%0d expected=1", tag, sb.size());
                end
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    check({tag, ".latency"}, 64'(lat), 64'(got.lat));
                    check({tag, ".rsp_err"}, 64'(rsp_err), 64'(got.err));
                    if (got.chk_data) check({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(got.rdata));
                end
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        checks++;
        assert (done)
        else begin
            failures++;
            $error("FAIL %s.rsp_timeout observed=%0d expected=%0d", tag, lat, exp_lat);
        end
        c1_cmd_in = 3'b110;
        @(negedge clk);
        check({tag, ".pulse_1cyc"}, 64'(rsp_valid), 64'd0);
        check({tag, ".ready_after"}, 64'(req_ready), 64'd1);
        if (chk_data) check({tag, ".rdata_hold"}, 64'(rsp_rdata), 64'(exp_rdata));
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_cmd    = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;
        c1_data_in = 16'h0;
        c1_cmd_in  = 3'b110;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst.req_ready", 64'(req_ready), 64'd1);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst.rsp_err", 64'(rsp_err), 64'd0);
        check("rst.rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst.c1_addr", 64'(c1_addr), 64'd0);
        check("rst.c1_data_out", 64'(c1_data_out), 64'd0);
        check("rst.c1_cmd_out", 64'(c1_cmd_out), 64'd0);
        check("rst.c1_cmd_oe", 64'(c1_cmd_oe), 64'd0);
        check("rst.c1_data_oe", 64'(c1_data_oe), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        //      cmd    addr       wdata          rsp lo        hi        chk  rdata          err lat
        run_txn(3'd0, 19'h00000, 32'h0,         0,  16'h0,    16'h0,    1'b0, 32'h0,         1'b0, 1,  "nop");
        run_txn(3'd1, 19'h12345, 32'h0,         3,  16'h12AB, 16'h0,    1'b1, 32'h000000AB,  1'b0, 4,  "read8");
        run_txn(3'd2, 19'h0ABCD, 32'h0,         4,  16'hBEEF, 16'h0,    1'b1, 32'h0000BEEF,  1'b0, 5,  "read16");
        run_txn(3'd3, 19'h001E0, 32'h0,         5,  16'hAAAA, 16'h5555, 1'b1, 32'h5555AAAA,  1'b0, 7,  "read32");
        run_txn(3'd3, 19'h7FFFF, 32'h0,         3,  16'h1234, 16'h5678, 1'b1, 32'h56781234,  1'b0, 5,  "read32_min");
        run_txn(3'd7, 19'h004E0, 32'hF0F00F0F,  4,  16'h0,    16'h0,    1'b0, 32'h0,         1'b0, 5,  "write32");
        run_txn(3'd5, 19'h00010, 32'h000000C3,  3,  16'h0,    16'h0,    1'b0, 32'h0,         1'b0, 4,  "write8");
        run_txn(3'd4, 19'h03300, 32'h0,         0,  16'h0,    16'h0,    1'b1, 32'h0,         1'b1, 67, "inv_timeout");

        // Reset in the middle of a WRITE16 WAIT abandons it silently.
        accept(3'd6, 19'h00A30, 32'h00001234, "w16_rst");
        @(negedge clk);
        @(negedge clk);
        check("w16_rst.wait_data_oe", 64'(c1_data_oe), 64'd1);
        check("w16_rst.wait_data", 64'(c1_data_out), 64'h1234);
        @(negedge clk);
        check("w16_rst.wait_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("w16_rst.cmd_oe", 64'(c1_cmd_oe), 64'd0);
        check("w16_rst.data_oe", 64'(c1_data_oe), 64'd0);
        check("w16_rst.rsp_valid", 64'(rsp_valid), 64'd0);
        check("w16_rst.req_ready", 64'(req_ready), 64'd1);
        check("w16_rst.rsp_err", 64'(rsp_err), 64'd0);
        rst_n = 1'b1;
        c1_cmd_in = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("w16_rst.no_rsp", 64'(rsp_valid), 64'd0);
        end
        c1_cmd_in = 3'b110;

        // Response on the same cycle the timeout expires wins.
        run_txn(3'd2, 19'h05550, 32'h0,        66, 16'h7E57, 16'h0,    1'b1, 32'h00007E57,  1'b0, 67, "expiry_race");

        checks++;
        assert (sb.size() == 0)
        else begin
            failures++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
